// File: rtl/baud_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : baud_cfg_ctrl
// Brief    : Baud-rate change controller for the UART clock handler. It drains
//            the UART, loads the new code, and waits for the clocks to settle.
//            The optional drain timeout is enabled by defining BAUD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module baud_cfg_ctrl #(
    parameter int         SETTLE_CYCLES  = 16,
    parameter logic [2:0] DEFAULT_BAUD   = 3'd2,
    parameter int         NUM_RATES      = 5,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_baud,
    output logic       req_ready,
    input  logic       uart_busy,
    output logic       uart_hold,
    output logic [2:0] baud,
    output logic       baud_ready,
    output logic [2:0] cur_baud,
    output logic       cfg_done,
    output logic       cfg_err
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_drain  = 3'd1;
    localparam logic [2:0] c_load   = 3'd2;
    localparam logic [2:0] c_settle = 3'd3;
    localparam logic [2:0] c_done   = 3'd4;

    // One counter serves both the settle wait and the optional drain timeout.
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
`ifdef BAUD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_req_baud;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             r_req_ready;
    logic             r_uart_hold;
    logic [2:0]       r_baud;
    logic             r_baud_ready;
    logic [2:0]       r_cur_baud;
    logic             r_cfg_done;
    logic             r_cfg_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_idle: begin
                if (req_valid && r_req_ready) begin
                    if ({29'd0, req_baud} >= 32'(NUM_RATES)) begin
                        w_err_nxt = 1'b1;
                    end else if (req_baud == r_cur_baud) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_drain;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            c_drain: begin
                if (!uart_busy) begin
                    w_state_nxt = c_load;
`ifdef BAUD_TIMEOUT_EN
                end else if (r_cnt == c_timeout_last) begin
                    w_state_nxt = c_idle;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
                end
            end
            c_load: begin
                w_state_nxt = c_settle;
                w_cnt_nxt   = '0;
            end
            c_settle: begin
                if (r_cnt == c_settle_last) begin
                    w_state_nxt = c_done;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            c_done: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_load;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_load;
            r_cnt        <= '0;
            r_req_baud   <= DEFAULT_BAUD;
            r_req_ready  <= 1'b0;
            r_uart_hold  <= 1'b1;
            r_baud       <= DEFAULT_BAUD;
            r_baud_ready <= 1'b0;
            r_cur_baud   <= DEFAULT_BAUD;
            r_cfg_done   <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req_ready  <= (w_state_nxt == c_idle);
            r_uart_hold  <= (w_state_nxt != c_idle);
            r_baud_ready <= (w_state_nxt != c_load);
            r_cfg_done   <= w_done_nxt;
            r_cfg_err    <= w_err_nxt;
            if (r_state == c_idle && w_state_nxt == c_drain) begin
                r_req_baud <= req_baud;
            end
            if (r_state == c_drain && w_state_nxt == c_load) begin
                r_baud <= r_req_baud;
            end
            if (w_state_nxt == c_done) begin
                r_cur_baud <= r_baud;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign uart_hold  = r_uart_hold;
    assign baud       = r_baud;
    assign baud_ready = r_baud_ready;
    assign cur_baud   = r_cur_baud;
    assign cfg_done   = r_cfg_done;
    assign cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/baud_cfg_ctrl.md
Name: baud_cfg_ctrl

Overview:
- Configuration controller for the UART clock handler: accepts baud-rate change requests and waits for the UART to go idle.
- Then drives the handler's `baud`/`baud_ready` handshake and holds the UART off until the new `clk_16bd`/`clk_bd` have settled.
- Sits between the register/control logic and `clock_handler`; the only block that writes the handler's `baud` and `baud_ready` inputs.

Parameters:
- SETTLE_CYCLES, 16: `clk` cycles `baud_ready` must be high before the new rate counts as stable (>=1).
- DEFAULT_BAUD, 3'd2: baud code loaded at reset.
- NUM_RATES, 5: valid codes are 0..NUM_RATES-1; codes >= NUM_RATES are rejected.
- TIMEOUT_CYCLES, 1024: drain timeout, used only with BAUD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  baud change request
- req_baud  in  3  requested baud code
- req_ready  out  1  controller can accept a request (high only in IDLE)
- uart_busy  in  1  TX or RX frame in progress
- uart_hold  out  1  UART must not start a new frame
- baud  out  3  baud code to clock_handler
- baud_ready  out  1  baud valid strobe to clock_handler
- cur_baud  out  3  currently active, settled code
- cfg_done  out  1  one-cycle pulse: request completed
- cfg_err  out  1  one-cycle pulse: request rejected or aborted

Behaviour:
- One clock, `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values:
  - `baud` = DEFAULT_BAUD, `cur_baud` = DEFAULT_BAUD.
  - `baud_ready` = 0, `uart_hold` = 1, `req_ready` = 0, `cfg_done` = 0, `cfg_err` = 0.
  - state = LOAD.
- States: IDLE, DRAIN, LOAD, SETTLE, DONE.
- IDLE:
  - Outputs: `req_ready` = 1, `uart_hold` = 0, `baud_ready` = 1.
  - Accept on `req_valid & req_ready` at edge N.
  - `req_baud` >= NUM_RATES: `cfg_err` = 1 during cycle N+1; stay IDLE.
  - `req_baud` == `cur_baud`: `cfg_done` = 1 during cycle N+1; stay IDLE; `baud_ready` stays high.
  - Otherwise: latch the code, go to DRAIN; `req_ready` = 0 and `uart_hold` = 1 from N+1.
- DRAIN:
  - `uart_hold` = 1, `baud_ready` = 1, `baud` unchanged.
  - Go to LOAD on the first cycle `uart_busy` is sampled 0.
  - `uart_busy` already 0 gives exactly one cycle in DRAIN.
- LOAD (exactly 1 cycle):
  - `baud_ready` = 0; `baud` = latched code; `uart_hold` = 1.
  - Then go to SETTLE.
- SETTLE:
  - `baud_ready` = 1; counter counts SETTLE_CYCLES cycles (0..SETTLE_CYCLES-1).
  - Then go to DONE.
- DONE (1 cycle):
  - `cfg_done` = 1; `cur_baud` <= `baud`; `uart_hold` still 1.
  - Then go to IDLE, where `uart_hold` = 0.
- After reset: LOAD -> SETTLE -> DONE with DEFAULT_BAUD, so a `cfg_done` pulse follows reset.
- Accept-to-`cfg_done` latency with `uart_busy` = 0: 1 (DRAIN) + 1 (LOAD) + SETTLE_CYCLES + 1 cycles after edge N.
- `req_valid` outside IDLE is ignored; the requester must hold it until `req_ready`.
- `req_baud` is sampled only at accept.
- `cfg_done` and `cfg_err` never assert in the same cycle.
- Reset asserted mid-operation (any state) returns to reset values and restarts the LOAD sequence with DEFAULT_BAUD. The pending request is discarded with no `cfg_err`.
- `uart_busy` toggling during LOAD/SETTLE is ignored; `uart_hold` guarantees no new frame starts.

Optional Feature:
- Macro: BAUD_TIMEOUT_EN.
- Defined: DRAIN counts cycles. If `uart_busy` is still 1 after TIMEOUT_CYCLES cycles in DRAIN:
  - Abort and return to IDLE; `cfg_err` = 1 for 1 cycle.
  - `baud`, `baud_ready` and `cur_baud` are unchanged; `uart_hold` is released.
- Not defined: DRAIN waits indefinitely; the timeout counter is not present.

Test Plan:
- Reset, SETTLE_CYCLES = 4, `uart_busy` = 0:
  - `baud` = 2 and `baud_ready` = 0 until LOAD ends, then 1.
  - `cfg_done` pulses once; `cur_baud` = 2; `req_ready` = 1 afterwards.
- In IDLE, request `req_baud` = 1, `uart_busy` = 0:
  - `baud_ready` low exactly one cycle, with `baud` = 1 from that cycle.
  - `cfg_done` at N+7; `cur_baud` = 1; `uart_hold` high N+1..N+7.
- Request `req_baud` = 3 with `uart_busy` = 1 for 20 cycles:
  - Stays in DRAIN with `baud` = 2 and `baud_ready` = 1 throughout.
  - LOAD starts the cycle after `uart_busy` falls; `cfg_done` follows.
- Request `req_baud` = 6 -> `cfg_err` pulse at N+1, no `baud`/`baud_ready` change. Request `req_baud` = `cur_baud` -> `cfg_done` at N+1, `baud_ready` stays 1.
- `rst` pulsed during SETTLE of a change to code 4:
  - `baud` returns to 2 and `baud_ready` to 0; the reset sequence replays.
  - `cur_baud` = 2; no `cfg_err`.
- With BAUD_TIMEOUT_EN, TIMEOUT_CYCLES = 8, `uart_busy` stuck at 1:
  - `cfg_err` after 8 DRAIN cycles; `uart_hold` = 0; `baud` unchanged.
